// File: rtl/col_drain_arbiter_pkg.sv
// Shared types and default sizing for the column drain arbiter.
package col_drain_arbiter_pkg;

    localparam int unsigned CDA_COLS     = 8;
    localparam int unsigned CDA_ROWS     = 8;
    localparam int unsigned CDA_OUTWIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } cda_state_t;

endpackage

// File: rtl/col_drain_arbiter_if.sv
// Bus bundle for the column drain arbiter: column buffer side, output
// stream side and the tile control/status strobes.
interface col_drain_arbiter_if #(
    parameter int unsigned COLS     = col_drain_arbiter_pkg::CDA_COLS,
    parameter int unsigned ROWS     = col_drain_arbiter_pkg::CDA_ROWS,
    parameter int unsigned OUTWIDTH = col_drain_arbiter_pkg::CDA_OUTWIDTH
);
    import col_drain_arbiter_pkg::*;

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);

    logic                               start;
    logic                               abort;
    logic [COLS-1:0][OUTWIDTH-1:0]      col_r;
    logic [COLS-1:0]                    col_v;
    logic [COLS-1:0]                    col_rread;
    logic [OUTWIDTH-1:0]                out_data;
    logic [CW-1:0]                      out_col;
    logic [RW-1:0]                      out_row;
    logic                               out_valid;
    logic                               out_ready;
    logic                               out_last;
    logic                               busy;
    logic                               done;

    modport slave (
        input  start, abort, col_r, col_v, out_ready,
        output col_rread, out_data, out_col, out_row, out_valid, out_last,
               busy, done
    );

    modport master (
        output start, abort, col_r, col_v, out_ready,
        input  col_rread, out_data, out_col, out_row, out_valid, out_last,
               busy, done
    );

endinterface

// File: rtl/col_drain_arbiter_out_reg_slice.sv
// One-entry valid/ready output register carrying data, source column,
// row index and the tile-last marker.
module out_reg_slice #(
    parameter int unsigned WIDTH = col_drain_arbiter_pkg::CDA_OUTWIDTH,
    parameter int unsigned CW    = 3,
    parameter int unsigned RW    = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CW-1:0]    i_col,
    input  logic [RW-1:0]    i_row,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_col,
    output logic [RW-1:0]    o_row,
    output logic             o_last
);
    import col_drain_arbiter_pkg::*;

    // Load has priority over drain so accept+capture sustains one beat per cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_col   <= '0;
            o_row   <= '0;
            o_last  <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_col   <= i_col;
            o_row   <= i_row;
            o_last  <= i_last;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/col_drain_arbiter.sv
// Drains one tile of COLS x ROWS results from per-column buffers in
// column-major order into a single registered valid/ready stream.
module col_drain_arbiter #(
    parameter int unsigned COLS     = col_drain_arbiter_pkg::CDA_COLS,
    parameter int unsigned ROWS     = col_drain_arbiter_pkg::CDA_ROWS,
    parameter int unsigned OUTWIDTH = col_drain_arbiter_pkg::CDA_OUTWIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    col_drain_arbiter_if.slave   bus
);
    import col_drain_arbiter_pkg::*;

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);

    cda_state_t     r_state;
    cda_state_t     w_state_nxt;
    logic [CW-1:0]  r_col_idx;
    logic [CW-1:0]  w_col_nxt;
    logic [RW-1:0]  r_row_idx;
    logic [RW-1:0]  w_row_nxt;
    logic           w_out_valid;
    logic           w_accept;
    logic           w_capture;
    logic           w_last_beat;

    assign w_last_beat = (r_col_idx == CW'(COLS - 1)) && (r_row_idx == RW'(ROWS - 1));
    assign w_accept    = w_out_valid && bus.out_ready;
    assign w_capture   = (r_state == ST_DRAIN) && !bus.abort &&
                         bus.col_v[r_col_idx] && (!w_out_valid || bus.out_ready);

    // Pop strobe: only the addressed column, only in a capture cycle.
    always_comb begin
        bus.col_rread            = '0;
        bus.col_rread[r_col_idx] = w_capture;
    end

    // State and drain-position registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_col_idx <= '0;
            r_row_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_col_idx <= w_col_nxt;
            r_row_idx <= w_row_nxt;
        end
    end

    // Next state and drain position; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col_idx;
        w_row_nxt   = r_row_idx;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = ST_DRAIN;
                        w_col_nxt   = '0;
                        w_row_nxt   = '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_capture) begin
                        if (r_row_idx == RW'(ROWS - 1)) begin
                            w_row_nxt = '0;
                            w_col_nxt = r_col_idx + CW'(1);
                        end else begin
                            w_row_nxt = r_row_idx + RW'(1);
                        end
                        if (w_last_beat) begin
                            w_state_nxt = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_accept) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    out_reg_slice #(
        .WIDTH (OUTWIDTH),
        .CW    (CW),
        .RW    (RW)
    ) u_out_reg (
        .clk     (clk),
        .rstn    (rstn),
        .i_flush (bus.abort),
        .i_load  (w_capture),
        .i_data  (bus.col_r[r_col_idx]),
        .i_col   (r_col_idx),
        .i_row   (r_row_idx),
        .i_last  (w_last_beat),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_data  (bus.out_data),
        .o_col   (bus.out_col),
        .o_row   (bus.out_row),
        .o_last  (bus.out_last)
    );

    assign bus.out_valid = w_out_valid;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_col_drain_arbiter.sv
// Bench for col_drain_arbiter: a tile-level model (pop count, output
// occupancy, done flag) predicts every output each cycle, plus directed
// literal checks on a 2x2 instance and on key corner cases.
module tb_col_drain_arbiter;

    localparam int C = 8;
    localparam int R = 8;
    localparam int W = 32;
    localparam int N = C * R;

    // Hand-derived 2x2 sequence, index = cycles after the start cycle.
    localparam int S_RR   [8] = '{0, 1, 1, 2, 2, 0, 0, 0};
    localparam int S_OV   [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    localparam int S_COL  [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    localparam int S_ROW  [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
    localparam int S_LAST [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    localparam int S_DONE [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    col_drain_arbiter_if #(.COLS(C), .ROWS(R), .OUTWIDTH(W)) bus ();
    col_drain_arbiter_if #(.COLS(2), .ROWS(2), .OUTWIDTH(W)) sbus ();

    col_drain_arbiter #(.COLS(C), .ROWS(R), .OUTWIDTH(W)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    col_drain_arbiter #(.COLS(2), .ROWS(2), .OUTWIDTH(W)) u_small (
        .clk  (clk),
        .rstn (rstn),
        .bus  (sbus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Tile model: tile active, pops issued, output register occupancy.
    bit   m_on, m_done, m_ov;
    int   m_pops, m_beat;

    logic [15:0] tag;
    int   hd [C];
    int   pops_seen, acc_n, last_at, last_col, last_row;
    bit   s_run;
    int   s_k;
    logic [C-1:0] rr_pre;
    bit   acc_pre, last_pre;
    int   col_pre, row_pre;
    logic [W-1:0] hold;

    function automatic logic [W-1:0] hv(int c, int r);
        return {tag, 16'(c * 16 + r)};
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_pop();
        if (!(rstn && m_on && !m_done && m_pops < N && !bus.abort)) return 1'b0;
        return bus.col_v[m_pops / R] && (!m_ov || bus.out_ready);
    endfunction

    function automatic void model_clear();
        m_on = 0; m_done = 0; m_ov = 0; m_pops = 0; m_beat = 0;
    endfunction

    function automatic void model_update();
        bit p, acc;
        if (!rstn) begin
            model_clear();
            return;
        end
        p   = exp_pop();
        acc = m_ov && bus.out_ready;
        if (bus.abort) begin
            model_clear();
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_on) begin
            if (bus.start) begin
                m_on = 1; m_pops = 0;
            end
        end else begin
            if (m_pops == N && acc) begin
                m_on = 0; m_done = 1;
            end
            if (p) begin
                m_ov = 1; m_beat = m_pops; m_pops++;
            end else if (acc) begin
                m_ov = 0;
            end
        end
    endfunction

    task automatic refresh();
        for (int c = 0; c < C; c++) bus.col_r[c] = hv(c, hd[c]);
    endtask

    task automatic compare();
        logic [C-1:0] exp_rr;
        n_vec++;
        exp_rr = '0;
        if (exp_pop()) exp_rr[m_pops / R] = 1'b1;
        chk("col_rread", W'(bus.col_rread), W'(exp_rr));
        chk("out_valid", W'(bus.out_valid), W'(m_ov));
        chk("busy", W'(bus.busy), W'(m_on || m_done));
        chk("done", W'(bus.done), W'(m_done));
        if (m_ov) begin
            chk("out_data", bus.out_data, hv(m_beat / R, m_beat % R));
            chk("out_col", W'(bus.out_col), W'(m_beat / R));
            chk("out_row", W'(bus.out_row), W'(m_beat % R));
            chk("out_last", W'(bus.out_last), W'(m_beat == N - 1));
        end
    endtask

    task automatic small_check(int k);
        chk("s_rread", W'(sbus.col_rread), W'(S_RR[k]));
        chk("s_valid", W'(sbus.out_valid), W'(S_OV[k]));
        chk("s_done", W'(sbus.done), W'(S_DONE[k]));
        if (S_OV[k] != 0) begin
            chk("s_col", W'(sbus.out_col), W'(S_COL[k]));
            chk("s_row", W'(sbus.out_row), W'(S_ROW[k]));
            chk("s_last", W'(sbus.out_last), W'(S_LAST[k]));
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        if (s_run && s_k < 8) small_check(s_k);
        rr_pre   = bus.col_rread;
        acc_pre  = bus.out_valid && bus.out_ready;
        last_pre = bus.out_last;
        col_pre  = int'(bus.out_col);
        row_pre  = int'(bus.out_row);
        @(posedge clk);
        model_update();
        for (int c = 0; c < C; c++) begin
            if (rr_pre[c]) begin
                hd[c]++;
                pops_seen++;
            end
        end
        if (acc_pre) begin
            acc_n++;
            if (last_pre) begin
                last_at = acc_n; last_col = col_pre; last_row = row_pre;
            end
        end
        if (s_run) s_k++;
        #1;
        refresh();
    endtask

    task automatic new_tile(input logic [15:0] t);
        tag = t;
        for (int c = 0; c < C; c++) hd[c] = 0;
        pops_seen = 0; acc_n = 0; last_at = 0; last_col = -1; last_row = -1;
        refresh();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic run_until_idle(int rdy_pct, int v_pct, int budget, bit rnd_start);
        int cyc;
        cyc = 0;
        while ((m_on || m_done) && cyc < budget) begin
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            for (int c = 0; c < C; c++) bus.col_v[c] = ($urandom_range(99) < v_pct);
            bus.start = rnd_start && ($urandom_range(7) == 0);
            step();
            cyc++;
        end
        bus.start = 1'b0;
        if (m_on || m_done) begin
            n_err++;
            $display("FAIL timeout: tile active after %0d cycles, required idle", budget);
        end
    endtask

    task automatic tile_stats(string name);
        chk({name, "_pops"}, W'(pops_seen), W'(N));
        chk({name, "_last_at"}, W'(last_at), W'(N));
        chk({name, "_last_col"}, W'(last_col), W'(C - 1));
        chk({name, "_last_row"}, W'(last_row), W'(R - 1));
    endtask

    initial begin
        rstn = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.col_v = '0; bus.out_ready = 1'b0;
        sbus.start = 1'b0; sbus.abort = 1'b0; sbus.col_v = 2'b11; sbus.out_ready = 1'b1;
        sbus.col_r = '0;
        s_run = 0; s_k = 0;
        tag = '0;
        for (int c = 0; c < C; c++) hd[c] = 0;
        pops_seen = 0; acc_n = 0; last_at = 0; last_col = 0; last_row = 0;
        model_clear();
        refresh();
        #2;
        chk("rst_busy", W'(bus.busy), '0);
        chk("rst_valid", W'(bus.out_valid), '0);
        chk("rst_data", bus.out_data, '0);
        chk("rst_rread", W'(bus.col_rread), '0);
        step();
        step();
        #3 rstn = 1'b1;

        // 2x2 instance, all columns valid, ready always high.
        s_run = 1; s_k = 0;
        sbus.start = 1'b1;
        step();
        sbus.start = 1'b0;
        repeat (7) step();
        s_run = 0;

        // Selected column not valid: no pop even though column 1 is valid.
        bus.out_ready = 1'b1;
        bus.col_v = 8'b0000_0010;
        new_tile(16'h00A5);
        repeat (4) begin
            step();
            chk("v0_low_pop", W'(bus.col_rread), '0);
            chk("v0_low_valid", W'(bus.out_valid), '0);
        end
        bus.col_v = '1;
        step();
        chk("first_valid", W'(bus.out_valid), 32'd1);
        chk("first_data", bus.out_data, 32'h00A5_0000);

        // Downstream stall: beat held, no pops, released on first ready cycle.
        bus.out_ready = 1'b0;
        hold = bus.out_data;
        repeat (3) begin
            step();
            chk("stall_data", bus.out_data, hold);
            chk("stall_pop", W'(bus.col_rread), '0);
            chk("stall_row", W'(bus.out_row), '0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("release_acc", W'(acc_n), 32'd1);
        chk("release_row", W'(bus.out_row), 32'd1);
        run_until_idle(70, 80, 2000, 1'b1);
        tile_stats("tile_a");

        // Full-rate tile with col_r[c] = c*16 + row.
        bus.col_v = '1; bus.out_ready = 1'b1;
        new_tile(16'h0000);
        run_until_idle(100, 100, 200, 1'b0);
        tile_stats("tile_full");

        // Randomized tiles at various pressure levels.
        for (int t = 0; t < 3; t++) begin
            new_tile(16'($urandom));
            run_until_idle(30 + 30 * t, 40 + 25 * t, 3000, 1'b1);
            tile_stats("tile_rand");
        end

        // Abort after the fifth pop, with start asserted alongside.
        bus.col_v = '1; bus.out_ready = 1'b1;
        new_tile(16'h0BAD);
        for (int g = 0; g < 20 && pops_seen < 5; g++) step();
        bus.abort = 1'b1; bus.start = 1'b1;
        step();
        bus.abort = 1'b0; bus.start = 1'b0;
        chk("abort_busy", W'(bus.busy), '0);
        chk("abort_valid", W'(bus.out_valid), '0);
        chk("abort_rread", W'(bus.col_rread), '0);
        step();
        step();
        chk("abort_pops", W'(pops_seen), 32'd5);
        new_tile(16'h0C0D);
        chk("restart_rread", W'(bus.col_rread), 32'h01);
        step();
        chk("restart_col", W'(bus.out_col), '0);
        chk("restart_row", W'(bus.out_row), '0);
        chk("restart_data", bus.out_data, 32'h0C0D_0000);
        run_until_idle(80, 90, 2000, 1'b0);
        tile_stats("tile_restart");

        // Reset in the middle of a drain.
        new_tile(16'($urandom));
        for (int i = 0; i < 20; i++) begin
            bus.out_ready = ($urandom_range(99) < 60);
            for (int c = 0; c < C; c++) bus.col_v[c] = ($urandom_range(99) < 70);
            step();
        end
        bus.col_v = '1; bus.out_ready = 1'b1;
        #1 rstn = 1'b0;
        model_clear();
        #1;
        chk("arst_busy", W'(bus.busy), '0);
        chk("arst_done", W'(bus.done), '0);
        chk("arst_valid", W'(bus.out_valid), '0);
        chk("arst_last", W'(bus.out_last), '0);
        chk("arst_data", bus.out_data, '0);
        chk("arst_col", W'(bus.out_col), '0);
        chk("arst_row", W'(bus.out_row), '0);
        chk("arst_rread", W'(bus.col_rread), '0);
        hold = W'(pops_seen);
        repeat (3) step();
        chk("arst_no_pop", W'(pops_seen), hold);
        #3 rstn = 1'b1;
        step();
        chk("post_rst_busy", W'(bus.busy), '0);
        new_tile(16'($urandom));
        run_until_idle(90, 90, 2000, 1'b0);
        tile_stats("tile_post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
